// File: rtl/vx_hpdcache_mem_wr_bridge.sv
// HPDcache write path joiner plus read/write merge onto a single registered mem bus request channel.
// Write acks are generated locally from a tag FIFO because the memory side never acknowledges writes.
module vx_hpdcache_mem_wr_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4,
  parameter int ACK_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
  input  logic [ID_WIDTH-1:0]     rd_req_id,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
  input  logic [ID_WIDTH-1:0]     wr_req_id,
  input  logic                    wr_data_valid,
  output logic                    wr_data_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_data_be,
  output logic                    wr_resp_valid,
  input  logic                    wr_resp_ready,
  output logic [ID_WIDTH-1:0]     wr_resp_id,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_rw,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_data,
  output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  output logic [ID_WIDTH-1:0]     mem_req_tag
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W    = $clog2(ACK_DEPTH);
  localparam int CNT_W    = $clog2(ACK_DEPTH + 1);

  logic                  addr_full, data_full;
  logic [ADDR_WIDTH-1:0] slot_addr;
  logic [ID_WIDTH-1:0]   slot_id;
  logic [DATA_WIDTH-1:0] slot_data;
  logic [BE_WIDTH-1:0]   slot_be;
  logic [CNT_W-1:0]      credits;
  logic                  prio_rd;

  logic [ID_WIDTH-1:0]   ack_mem [ACK_DEPTH];
  logic [PTR_W-1:0]      ack_wptr, ack_rptr;
  logic [PTR_W:0]        ack_count;

  logic load_en, wr_cand, grant_rd, grant_wr, wr_load, ack_push, ack_pop, ack_empty;

  assign load_en   = !mem_req_valid || mem_req_ready;
  assign wr_cand   = addr_full && data_full && (credits != '0);
  assign wr_load   = load_en && grant_wr;
  assign ack_empty = (ack_count == '0);
  assign ack_push  = mem_req_valid && mem_req_ready && mem_req_rw;
  assign ack_pop   = wr_resp_valid && wr_resp_ready;

  // Uncontested requests win outright; a contested pair goes to whichever side holds priority.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (rd_req_valid && (!wr_cand || prio_rd)) grant_rd = 1'b1;
    else if (wr_cand)                          grant_wr = 1'b1;
  end

  assign rd_req_ready  = load_en && grant_rd;
  assign wr_req_ready  = !addr_full;
  assign wr_data_ready = !data_full;
  assign wr_resp_valid = !ack_empty;
  assign wr_resp_id    = ack_empty ? '0 : ack_mem[ack_rptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_full <= 1'b0;
      data_full <= 1'b0;
      slot_addr <= '0;
      slot_id   <= '0;
      slot_data <= '0;
      slot_be   <= '0;
    end else begin
      if (wr_load) begin
        addr_full <= 1'b0;
        data_full <= 1'b0;
      end
      if (wr_req_valid && wr_req_ready) begin
        addr_full <= 1'b1;
        slot_addr <= wr_req_addr;
        slot_id   <= wr_req_id;
      end
      if (wr_data_valid && wr_data_ready) begin
        data_full <= 1'b1;
        slot_data <= wr_data;
        slot_be   <= wr_data_be;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits <= CNT_W'(ACK_DEPTH);
      prio_rd <= 1'b1;
    end else begin
      case ({wr_load, ack_pop})
        2'b10:   credits <= credits - CNT_W'(1);
        2'b01:   credits <= credits + CNT_W'(1);
        default: ;
      endcase
      if (load_en && rd_req_valid && wr_cand) prio_rd <= !prio_rd;
    end
  end

  // Output register only reloads when empty or draining, so a stalled request never changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_valid  <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      mem_req_byteen <= '0;
      mem_req_tag    <= '0;
    end else if (load_en) begin
      mem_req_valid <= grant_rd || grant_wr;
      if (grant_rd) begin
        mem_req_rw     <= 1'b0;
        mem_req_addr   <= rd_req_addr;
        mem_req_data   <= '0;
        mem_req_byteen <= '1;
        mem_req_tag    <= rd_req_id;
      end else if (grant_wr) begin
        mem_req_rw     <= 1'b1;
        mem_req_addr   <= slot_addr;
        mem_req_data   <= slot_data;
        mem_req_byteen <= slot_be;
        mem_req_tag    <= slot_id;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_wptr  <= '0;
      ack_rptr  <= '0;
      ack_count <= '0;
    end else begin
      if (ack_push) ack_wptr <= ack_wptr + PTR_W'(1);
      if (ack_pop)  ack_rptr <= ack_rptr + PTR_W'(1);
      case ({ack_push, ack_pop})
        2'b10:   ack_count <= ack_count + (PTR_W+1)'(1);
        2'b01:   ack_count <= ack_count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count define validity and the empty head reads as zero.
  always_ff @(posedge clk) begin
    if (ack_push) ack_mem[ack_wptr] <= mem_req_tag;
  end

  // Credits bound writes in flight to ACK_DEPTH, so a push into a full FIFO means the credit logic broke.
  assert property (@(posedge clk) disable iff (!reset_n)
    !(ack_push && !ack_pop && (ack_count == (PTR_W+1)'(ACK_DEPTH))));

endmodule
